// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory port: store-size encodings
// (also decoded by the cpu controller) and the default memory depth.
package dm_responder_pkg;

  localparam int DM_ADDR_W = 12;

  typedef enum logic [1:0] {
    LEN_WORD = 2'b00,
    LEN_HALF = 2'b01,
    LEN_BYTE = 2'b10,
    LEN_RSVD = 2'b11
  } dm_len_e;

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane merge for a sub-word store: works out which lanes a store
// touches, whether its address is legal for its size, and the merged word.
module dm_lane_merge
  import dm_responder_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic        aligned
);

  logic [31:0] lane_data;

  // Sub-word values are replicated across the word so the lane enables pick them out.
  always_comb begin
    be        = 4'b0000;
    lane_data = 32'h0;
    aligned   = 1'b0;
    case (dm_len_e'(len))
      LEN_WORD: begin
        be        = 4'b1111;
        lane_data = wdata;
        aligned   = (byte_off == 2'b00);
      end
      LEN_HALF: begin
        be        = 4'b0011 << byte_off;
        lane_data = {2{wdata[15:0]}};
        aligned   = ~byte_off[0];
      end
      LEN_BYTE: begin
        be        = 4'b0001 << byte_off;
        lane_data = {4{wdata[7:0]}};
        aligned   = 1'b1;
      end
      default: begin
        be        = 4'b0000;
        lane_data = 32'h0;
        aligned   = 1'b0;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Memory side of the cpu data port: combinational word reads, clocked
// sub-word stores, a registered store trace and a sticky store-fault record.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          ADDR_W = DM_ADDR_W,
  parameter logic [31:0] BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DMAdr,
  input  logic        DMcurWE,
  input  logic [1:0]  DMWLen,
  input  logic [31:0] DMDataW,
  input  logic [31:0] DMcurPC,
  output logic [31:0] DMDataR,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] store_count
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  logic [32:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_word;
  logic [3:0]        lane_be;
  logic [31:0]       merged;
  logic              aligned;
  logic              accept;

  logic        trace_valid_q, trace_valid_d;
  logic [31:0] trace_pc_q, trace_pc_d;
  logic [31:0] trace_addr_q, trace_addr_d;
  logic [31:0] trace_data_q, trace_data_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] store_count_q, store_count_d;

  // 33-bit offset so a window ending at the top of the address space cannot wrap.
  always_comb begin
    offset   = {1'b0, DMAdr} - {1'b0, BASE};
    in_range = (DMAdr >= BASE) && (offset < SPAN);
    idx      = offset[ADDR_W+1:2];
    old_word = mem_q[idx];
    DMDataR  = in_range ? old_word : 32'h0;
  end

  dm_lane_merge u_lane_merge (
    .old_word (old_word),
    .byte_off (DMAdr[1:0]),
    .len      (DMWLen),
    .wdata    (DMDataW),
    .be       (lane_be),
    .merged   (merged),
    .aligned  (aligned)
  );

  // The reserved size enables no lanes, so it can never be accepted.
  assign accept = DMcurWE & in_range & aligned & (|lane_be);

  always_comb begin
    trace_valid_d = 1'b0;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    store_count_d = store_count_q;
    if (accept) begin
      trace_valid_d = 1'b1;
      trace_pc_d    = DMcurPC;
      trace_addr_d  = {DMAdr[31:2], 2'b00};
      trace_data_d  = merged;
      store_count_d = store_count_q + 32'd1;
    end else if (DMcurWE && !fault_q) begin
      fault_d    = 1'b1;
      fault_pc_d = DMcurPC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= 32'h0;
      trace_addr_q  <= 32'h0;
      trace_data_q  <= 32'h0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'h0;
      store_count_q <= 32'h0;
    end else begin
      if (accept) mem_q[idx] <= merged;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      store_count_q <= store_count_d;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a table of store/read vectors with
// hand-derived results, a trace scoreboard, and reset corner cases.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DMAdr;
  logic        DMcurWE;
  logic [1:0]  DMWLen;
  logic [31:0] DMDataW;
  logic [31:0] DMcurPC;
  logic [31:0] DMDataR;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] store_count;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rd_before;
    logic [31:0] rd_after;
    logic        exp_trace;
    logic [31:0] exp_tdata;
    logic [31:0] exp_count;
    logic        exp_fault;
    logic [31:0] exp_fpc;
  } vec_t;

  trace_t exp_q[$];
  vec_t   vecs[13];

  dm_responder #(.ADDR_W(12), .BASE(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .DMAdr       (DMAdr),
    .DMcurWE     (DMcurWE),
    .DMWLen      (DMWLen),
    .DMDataW     (DMDataW),
    .DMcurPC     (DMcurPC),
    .DMDataR     (DMDataR),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic we, input logic [1:0] len,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input logic [31:0] rd_before, input logic [31:0] rd_after,
                              input logic exp_trace, input logic [31:0] exp_tdata,
                              input logic [31:0] exp_count, input logic exp_fault,
                              input logic [31:0] exp_fpc);
    vec_t v;
    v.addr = addr; v.we = we; v.len = len; v.wdata = wdata; v.pc = pc;
    v.rd_before = rd_before; v.rd_after = rd_after; v.exp_trace = exp_trace;
    v.exp_tdata = exp_tdata; v.exp_count = exp_count; v.exp_fault = exp_fault;
    v.exp_fpc = exp_fpc;
    return v;
  endfunction

  // Every committed store must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && trace_valid) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL trace_unexpected: got pulse pc=0x%08h, expected no pulse", trace_pc);
      end else begin
        trace_t e;
        e = exp_q.pop_front();
        checkOutput("trace_pc", trace_pc, e.pc);
        checkOutput("trace_addr", trace_addr, e.addr);
        checkOutput("trace_data", trace_data, e.data);
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int n);
    DMAdr   = v.addr;
    DMcurWE = v.we;
    DMWLen  = v.len;
    DMDataW = v.wdata;
    DMcurPC = v.pc;
    #1;
    checkOutput($sformatf("rd_before[%0d]", n), DMDataR, v.rd_before);
    if (v.exp_trace) exp_q.push_back('{v.pc, {v.addr[31:2], 2'b00}, v.exp_tdata});
    @(posedge clk);
    #1;
    checkOutput($sformatf("rd_after[%0d]", n), DMDataR, v.rd_after);
    checkOutput($sformatf("trace_valid[%0d]", n), {31'h0, trace_valid}, {31'h0, v.exp_trace});
    checkOutput($sformatf("store_count[%0d]", n), store_count, v.exp_count);
    checkOutput($sformatf("fault[%0d]", n), {31'h0, fault}, {31'h0, v.exp_fault});
    checkOutput($sformatf("fault_pc[%0d]", n), fault_pc, v.exp_fpc);
  endtask

  initial begin
    //            addr         we    len    wdata         pc          before        after         tr    tdata         cnt f  fpc
    vecs[0]  = mk(32'h10,   1'b1, 2'b00, 32'h12345678, 32'h3000, 32'h0,        32'h12345678, 1'b1, 32'h12345678, 1, 0, 32'h0);
    vecs[1]  = mk(32'h11,   1'b1, 2'b10, 32'h000000AB, 32'h3004, 32'h12345678, 32'h1234AB78, 1'b1, 32'h1234AB78, 2, 0, 32'h0);
    vecs[2]  = mk(32'h22,   1'b1, 2'b01, 32'h0000BEEF, 32'h3010, 32'h0,        32'hBEEF0000, 1'b1, 32'hBEEF0000, 3, 0, 32'h0);
    vecs[3]  = mk(32'h13,   1'b1, 2'b00, 32'hCAFEF00D, 32'h3008, 32'h1234AB78, 32'h1234AB78, 1'b0, 32'h0,        3, 1, 32'h3008);
    vecs[4]  = mk(32'h15,   1'b1, 2'b01, 32'h00005555, 32'h300C, 32'h0,        32'h0,        1'b0, 32'h0,        3, 1, 32'h3008);
    vecs[5]  = mk(32'h4000, 1'b1, 2'b00, 32'hDEADBEEF, 32'h3014, 32'h0,        32'h0,        1'b0, 32'h0,        3, 1, 32'h3008);
    vecs[6]  = mk(32'h0,    1'b1, 2'b11, 32'h11111111, 32'h3018, 32'h0,        32'h0,        1'b0, 32'h0,        3, 1, 32'h3008);
    vecs[7]  = mk(32'h3FFF, 1'b1, 2'b10, 32'h0000005A, 32'h301C, 32'h0,        32'h5A000000, 1'b1, 32'h5A000000, 4, 1, 32'h3008);
    vecs[8]  = mk(32'h3FFE, 1'b1, 2'b01, 32'h00001234, 32'h3020, 32'h5A000000, 32'h12340000, 1'b1, 32'h12340000, 5, 1, 32'h3008);
    vecs[9]  = mk(32'h10,   1'b0, 2'b00, 32'hFFFFFFFF, 32'h3024, 32'h1234AB78, 32'h1234AB78, 1'b0, 32'h0,        5, 1, 32'h3008);
    vecs[10] = mk(32'h23,   1'b1, 2'b10, 32'h000000CD, 32'h3028, 32'hBEEF0000, 32'hCDEF0000, 1'b1, 32'hCDEF0000, 6, 1, 32'h3008);
    vecs[11] = mk(32'h20,   1'b1, 2'b01, 32'hAAAA7777, 32'h302C, 32'hCDEF0000, 32'hCDEF7777, 1'b1, 32'hCDEF7777, 7, 1, 32'h3008);
    vecs[12] = mk(32'h12,   1'b1, 2'b10, 32'hFFFFFF99, 32'h3030, 32'h1234AB78, 32'h1299AB78, 1'b1, 32'h1299AB78, 8, 1, 32'h3008);

    reset   = 1'b1;
    DMAdr   = 32'h0;
    DMcurWE = 1'b0;
    DMWLen  = 2'b00;
    DMDataW = 32'h0;
    DMcurPC = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset_rd_0x0000", DMDataR, 32'h0);
    DMAdr = 32'h3FFC;
    #1;
    checkOutput("reset_rd_0x3FFC", DMDataR, 32'h0);
    checkOutput("reset_fault", {31'h0, fault}, 32'h0);
    checkOutput("reset_fault_pc", fault_pc, 32'h0);
    checkOutput("reset_count", store_count, 32'h0);
    checkOutput("reset_trace_valid", {31'h0, trace_valid}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Idle cycle: pulse drops, trace fields hold the last committed store.
    DMcurWE = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_trace_valid", {31'h0, trace_valid}, 32'h0);
    checkOutput("idle_trace_pc", trace_pc, 32'h3030);
    checkOutput("idle_trace_addr", trace_addr, 32'h10);
    checkOutput("idle_trace_data", trace_data, 32'h1299AB78);
    checkOutput("idle_count", store_count, 32'd8);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    // Reset wins over a same-cycle store and clears every word and the fault.
    DMAdr   = 32'h0;
    DMcurWE = 1'b1;
    DMWLen  = 2'b00;
    DMDataW = 32'hFFFFFFFF;
    DMcurPC = 32'h4000;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    DMcurWE = 1'b0;
    #1;
    checkOutput("rst_store_rd_0x0", DMDataR, 32'h0);
    checkOutput("rst_store_trace_valid", {31'h0, trace_valid}, 32'h0);
    checkOutput("rst_store_count", store_count, 32'h0);
    checkOutput("rst_store_fault", {31'h0, fault}, 32'h0);
    checkOutput("rst_store_fault_pc", fault_pc, 32'h0);
    DMAdr = 32'h10;
    #1;
    checkOutput("rst_store_rd_0x10", DMDataR, 32'h0);
    DMAdr = 32'h3FFC;
    #1;
    checkOutput("rst_store_rd_0x3FFC", DMDataR, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_trace_valid", {31'h0, trace_valid}, 32'h0);
    checkOutput("post_rst_count", store_count, 32'h0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
